// File: rtl/imm11_packer.sv
// Narrows 32-bit operand words to the 11-bit ZAFx32 immediate field with a range check.
// The fit flag is stored with each field, results pass through a 2-deep skid buffer,
// and saturating counters track accepted and overflowing words.
module imm11_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:IN_W-1]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:OUT_W-1] out_field,
    output logic             out_fits,
    input  logic             clr_stats,
    output logic [0:15]      count_total,
    output logic [0:15]      count_ovf
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Signed fit: every bit from the MSB down to the field's sign bit agrees.
    function automatic logic fits_signed(input logic [0:IN_W-1] w);
        logic [0:IN_W-OUT_W] hi;
        hi = w[0:IN_W-OUT_W];
        return (&hi) | (~|hi);
    endfunction

    // Unsigned fit: every bit above the field is zero.
    function automatic logic fits_unsigned(input logic [0:IN_W-1] w);
        logic [0:IN_W-OUT_W-1] hi;
        hi = w[0:IN_W-OUT_W-1];
        return ~|hi;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [0:OUT_W-1]   or_field_r, or_field_nxt_s;
    logic               or_fits_r, or_fits_nxt_s;
    logic               or_valid_r, or_valid_nxt_s;
    logic [0:OUT_W-1]   sk_field_r, sk_field_nxt_s;
    logic               sk_fits_r, sk_fits_nxt_s;
    logic               sk_valid_r, sk_valid_nxt_s;
    logic [15:0]        total_r, total_nxt_s;
    logic [15:0]        ovf_r, ovf_nxt_s;
    logic               accept_s;
    logic               new_fits_s;
    logic [0:OUT_W-1]   new_field_s;

    // Accept decision and per-word pack/range-check of the incoming word.
    always_comb begin
        accept_s    = in_valid & ~sk_valid_r;
        new_field_s = in_data[IN_W-OUT_W:IN_W-1];
        if (in_mode) begin
            new_fits_s = fits_unsigned(in_data);
        end else begin
            new_fits_s = fits_signed(in_data);
        end
    end

    // Skid-buffer next state: OR/SK contents follow the EMPTY/ONE/TWO occupancy.
    always_comb begin
        state_nxt_s    = state_r;
        or_field_nxt_s = or_field_r;
        or_fits_nxt_s  = or_fits_r;
        sk_field_nxt_s = sk_field_r;
        sk_fits_nxt_s  = sk_fits_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s    = ST_ONE;
                    or_field_nxt_s = new_field_s;
                    or_fits_nxt_s  = new_fits_s;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && out_ready) begin
                    or_field_nxt_s = new_field_s;
                    or_fits_nxt_s  = new_fits_s;
                end else if (accept_s) begin
                    state_nxt_s    = ST_TWO;
                    sk_field_nxt_s = new_field_s;
                    sk_fits_nxt_s  = new_fits_s;
                end else if (out_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    state_nxt_s    = ST_ONE;
                    or_field_nxt_s = sk_field_r;
                    or_fits_nxt_s  = sk_fits_r;
                end else begin
                    state_nxt_s = ST_TWO;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
        or_valid_nxt_s = (state_nxt_s != ST_EMPTY);
        sk_valid_nxt_s = (state_nxt_s == ST_TWO);
    end

    // Statistics next state: clear wins over a same-cycle accept.
    always_comb begin
        total_nxt_s = total_r;
        ovf_nxt_s   = ovf_r;
        if (clr_stats) begin
            total_nxt_s = 16'd0;
            ovf_nxt_s   = 16'd0;
        end else if (accept_s) begin
            total_nxt_s = sat_inc(total_r);
            if (!new_fits_s) begin
                ovf_nxt_s = sat_inc(ovf_r);
            end else begin
                ovf_nxt_s = ovf_r;
            end
        end else begin
            total_nxt_s = total_r;
            ovf_nxt_s   = ovf_r;
        end
    end

    // State, buffer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            or_field_r <= {OUT_W{1'b0}};
            or_fits_r  <= 1'b0;
            or_valid_r <= 1'b0;
            sk_field_r <= {OUT_W{1'b0}};
            sk_fits_r  <= 1'b0;
            sk_valid_r <= 1'b0;
            total_r    <= 16'd0;
            ovf_r      <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            or_field_r <= or_field_nxt_s;
            or_fits_r  <= or_fits_nxt_s;
            or_valid_r <= or_valid_nxt_s;
            sk_field_r <= sk_field_nxt_s;
            sk_fits_r  <= sk_fits_nxt_s;
            sk_valid_r <= sk_valid_nxt_s;
            total_r    <= total_nxt_s;
            ovf_r      <= ovf_nxt_s;
        end
    end

    assign in_ready    = ~sk_valid_r;
    assign out_valid   = or_valid_r;
    assign out_field   = or_field_r;
    assign out_fits    = or_fits_r;
    assign count_total = total_r;
    assign count_ovf   = ovf_r;

endmodule

// File: tb/tb_imm11_packer.sv
// Directed bench for imm11_packer: vector table for the pack/fit function plus
// hand-written sequences for backpressure, mid-operation reset, saturation and clear.
module tb_imm11_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [0:10] out_field;
    logic        out_fits;
    logic        clr_stats;
    logic [0:15] count_total;
    logic [0:15] count_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_total = 0;
    int exp_ovf   = 0;

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic [10:0] field;
        logic        fits;
    } vec_t;

    vec_t vecs[10];

    imm11_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_field  (out_field),
        .out_fits   (out_fits),
        .clr_stats  (clr_stats),
        .count_total(count_total),
        .count_ovf  (count_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{32'h000003FF, 1'b0, 11'h3FF, 1'b1};
        vecs[1] = '{32'h00000400, 1'b0, 11'h400, 1'b0};
        vecs[2] = '{32'hFFFFFC00, 1'b0, 11'h400, 1'b1};
        vecs[3] = '{32'hFFFFFBFF, 1'b0, 11'h3FF, 1'b0};
        vecs[4] = '{32'h000007FF, 1'b1, 11'h7FF, 1'b1};
        vecs[5] = '{32'h00000800, 1'b1, 11'h000, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 1'b1, 11'h7FF, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 1'b0, 11'h7FF, 1'b1};
        vecs[8] = '{32'h80000000, 1'b0, 11'h000, 1'b0};
        vecs[9] = '{32'h00000000, 1'b1, 11'h000, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        clr_stats = 1'b0;

        #12;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_field", {21'd0, out_field}, 32'd0);
        check("reset out_fits", {31'd0, out_fits}, 32'd0);
        check("reset count_total", {16'd0, count_total}, 32'd0);
        check("reset count_ovf", {16'd0, count_ovf}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        // Streaming table, one word per cycle with out_ready high.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            in_mode  = vecs[i].mode;
            @(posedge clk);
            #1;
            exp_total++;
            if (!vecs[i].fits) exp_ovf++;
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d out_field", i), {21'd0, out_field}, {21'd0, vecs[i].field});
            check($sformatf("vec%0d out_fits", i), {31'd0, out_fits}, {31'd0, vecs[i].fits});
            check($sformatf("vec%0d count_total", i), {16'd0, count_total}, exp_total);
            check($sformatf("vec%0d count_ovf", i), {16'd0, count_ovf}, exp_ovf);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: A and B accepted, C blocked until OR drains.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = 32'h00000005;
        @(posedge clk);
        #1;
        check("bp A out_field", {21'd0, out_field}, 32'h5);
        check("bp A in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_data = 32'h00000006;
        @(posedge clk);
        #1;
        check("bp B in_ready", {31'd0, in_ready}, 32'd0);
        check("bp B held field", {21'd0, out_field}, 32'h5);
        @(negedge clk);
        in_data = 32'h00000007;
        @(posedge clk);
        #1;
        check("bp stall field", {21'd0, out_field}, 32'h5);
        check("bp stall out_valid", {31'd0, out_valid}, 32'd1);
        check("bp stall in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp drain B field", {21'd0, out_field}, 32'h6);
        check("bp drain in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp C field", {21'd0, out_field}, 32'h7);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp empty out_valid", {31'd0, out_valid}, 32'd0);
        exp_total += 3;
        check("bp count_total", {16'd0, count_total}, exp_total);
        check("bp count_ovf", {16'd0, count_ovf}, exp_ovf);

        // Reset mid-operation with the buffer full.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00000400;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'h00000022;
        @(posedge clk);
        #1;
        check("full in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_field", {21'd0, out_field}, 32'd0);
        check("midrst out_fits", {31'd0, out_fits}, 32'd0);
        check("midrst count_total", {16'd0, count_total}, 32'd0);
        check("midrst count_ovf", {16'd0, count_ovf}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = 32'h00000123;
        @(posedge clk);
        #1;
        check("post-rst out_valid", {31'd0, out_valid}, 32'd1);
        check("post-rst out_field", {21'd0, out_field}, 32'h123);
        check("post-rst out_fits", {31'd0, out_fits}, 32'd1);
        check("post-rst count_total", {16'd0, count_total}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;

        // Saturation: clear, preload to FFFE with overflowing words, then 3 more.
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        check("clr count_total", {16'd0, count_total}, 32'd0);
        check("clr count_ovf", {16'd0, count_ovf}, 32'd0);
        @(negedge clk);
        clr_stats = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = 32'h00000800;
        repeat (65534) @(posedge clk);
        #1;
        check("preload count_total", {16'd0, count_total}, 32'hFFFE);
        check("preload count_ovf", {16'd0, count_ovf}, 32'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat count_total", {16'd0, count_total}, 32'hFFFF);
        check("sat count_ovf", {16'd0, count_ovf}, 32'hFFFF);
        @(negedge clk);
        clr_stats = 1'b1;
        in_mode   = 1'b0;
        in_data   = 32'h00000005;
        @(posedge clk);
        #1;
        check("clr+acc count_total", {16'd0, count_total}, 32'd0);
        check("clr+acc count_ovf", {16'd0, count_ovf}, 32'd0);
        check("clr+acc out_field", {21'd0, out_field}, 32'h5);
        check("clr+acc out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        clr_stats = 1'b0;
        in_data   = 32'h00000400;
        @(posedge clk);
        #1;
        check("after clr count_total", {16'd0, count_total}, 32'd1);
        check("after clr count_ovf", {16'd0, count_ovf}, 32'd1);
        check("after clr out_fits", {31'd0, out_fits}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm11_packer.md
# imm11_packer

- Narrows 32-bit operand words into the 11-bit immediate field format used by the ZAFx32 instruction encoding. It is the inverse of the datapath's 11-to-32-bit immediate extension.
- Each accepted word is range-checked, truncated to 11 bits and flagged as fitting or overflowing. Results leave through a 2-deep skid buffer with valid/ready handshakes on both sides.
- Sits between the instruction loader/assembler path and instruction memory. Keeps saturating statistics on accepted and overflowing words.

## Interface

Parameters
- IN_W, 32, input word width; only 32 is supported.
- OUT_W, 11, immediate field width; only 11 is supported.

Ports (vectors are [0:N]; bit 0 is the MSB)
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data and in_mode are valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  [0:31]  word to be packed.
- in_mode  in  1  0 = signed range check; 1 = unsigned range check.
- out_valid  out  1  out_field and out_fits are valid.
- out_ready  in  1  downstream consumes the result this cycle.
- out_field  out  [0:10]  truncated field, equal to in_data[21:31].
- out_fits  out  1  1 = the word is representable in the field under the selected mode.
- clr_stats  in  1  synchronous clear of both counters.
- count_total  out  [0:15]  accepted words, saturating at 16'hFFFF.
- count_ovf  out  [0:15]  accepted words with fits = 0, saturating at 16'hFFFF.

## Operation

- **Accept:** a word is accepted when in_valid && in_ready on a rising edge.
- **Signed fit (in_mode = 0):** in_data[0:21] all equal, i.e. the value is in -1024..1023. When it fits, sign-extending out_field back to 32 bits reproduces in_data exactly.
- **Unsigned fit (in_mode = 1):** in_data[0:20] all zero, i.e. the value is in 0..2047.
- **out_field:** always in_data[21:31], whether or not the word fits. The fit result is computed combinationally at accept time and stored with the field.
- **Storage:** an output register (OR) and a skid register (SK), each holding field + fits + a valid bit. States:
  - EMPTY: OR invalid, SK invalid. Accept -> ONE, word loaded into OR.
  - ONE: OR valid, SK invalid.
    - Accept && out_ready -> ONE; OR reloaded with the new word.
    - Accept && !out_ready -> TWO; new word stored in SK.
    - No accept && out_ready -> EMPTY.
    - Otherwise hold.
  - TWO: OR valid, SK valid. out_ready -> ONE; SK moves into OR, SK invalidated. Otherwise hold.
- in_ready = !SK.valid, driven from registered state only; no combinational path from out_ready.
- out_valid = OR.valid. out_field and out_fits come from OR.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- **Counters:** on accept, count_total += 1, and count_ovf += 1 if fits = 0. Both saturate at 16'hFFFF and do not wrap.
- **clr_stats:** sets both counters to 0 on the next edge. clr_stats takes priority over a simultaneous accept, so that word is not counted. It has no effect on the data path.

## Timing

- Latency: a word accepted at edge N appears on out_valid/out_field/out_fits after edge N, i.e. one cycle.
- Throughput: one word per cycle while out_ready = 1.
- Outputs are held stable while out_valid && !out_ready.
- in_ready deasserts the cycle after the buffer reaches TWO. It reasserts the cycle after OR is consumed.
- Counters update on the same edge as the accept.
- Reset (rst_n = 0, asynchronous, any state, including mid-transfer):
  - State forced to EMPTY, all held words discarded.
  - out_valid = 0, out_field = 11'd0, out_fits = 0.
  - count_total = 0, count_ovf = 0.
  - in_ready = 1.
- First accept is possible on the first rising edge after rst_n rises.

## Test plan

- **Signed fit/overflow:** in_mode = 0, stream 32'h000003FF, 32'h00000400, 32'hFFFFFC00, 32'hFFFFFBFF with out_ready = 1 -> four results on consecutive cycles:
  - field 11'h3FF / 11'h400 / 11'h400 / 11'h3FF
  - fits 1 / 0 / 1 / 0
  - count_total = 4, count_ovf = 2.
- **Unsigned fit/overflow:** in_mode = 1, stream 32'h000007FF, 32'h00000800, 32'hFFFFFFFF -> fields 11'h7FF / 11'h000 / 11'h7FF, fits 1 / 0 / 0.
- **Backpressure:** out_ready = 0 with in_valid held.
  - Two words are accepted, then in_ready = 0 and the first word is held stable.
  - Raise out_ready -> words emerge in order, no loss, and in_ready returns to 1.
- **Saturation and clear:**
  - Preload counters to 16'hFFFE (accept 65534 overflowing words), then accept 3 more -> both counters read 16'hFFFF.
  - clr_stats asserted together with an accept -> both counters read 0.
- **Reset mid-operation:** fill to TWO, then pulse rst_n low between clock edges -> out_valid, out_field, out_fits and both counters drop to 0 immediately; in_ready = 1. After release, the next word passes with 1-cycle latency.
